// File: rtl/queue_fifo.sv
// Synchronous first-word-fall-through FIFO queue with count-derived status
// flags and sticky overflow/underflow indicators.
module queue_fifo #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned AF_LEVEL   = (2 ** ADDR_WIDTH) - 2,
   parameter int unsigned AE_LEVEL   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  empty,
   output logic                  full,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
   localparam int unsigned CW    = ADDR_WIDTH + 1;

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;

   logic            push_ok;
   logic            pop_ok;
   logic            push_rej;
   logic            pop_rej;
   logic [CW-1:0]   count_nxt;

   // Accept/reject decisions and next occupancy.
   // A push into a full queue is still accepted when a pop frees the head slot
   // in the same cycle; a pop on an empty queue is only flagged when no push
   // accompanies it.
   always_comb begin
      push_ok   = 1'b0;
      pop_ok    = 1'b0;
      push_rej  = 1'b0;
      pop_rej   = 1'b0;
      count_nxt = count;

      pop_ok   = pop && !empty;
      push_ok  = push && (!full || pop_ok);
      push_rej = push && !push_ok;
      pop_rej  = pop && !pop_ok && !push;

      if (push_ok && !pop_ok) begin
         count_nxt = count + CW'(1);
      end else if (pop_ok && !push_ok) begin
         count_nxt = count - CW'(1);
      end
   end

   // Pointers, occupancy, status flags and sticky error bits.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         empty        <= 1'b1;
         full         <= 1'b0;
         almost_full  <= (AF_C == '0);
         almost_empty <= 1'b1;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
         end
         count        <= count_nxt;
         empty        <= (count_nxt == '0);
         full         <= (count_nxt == DEPTH_C);
         almost_full  <= (count_nxt >= AF_C);
         almost_empty <= (count_nxt <= AE_C);
         overflow     <= overflow | push_rej;
         underflow    <= underflow | pop_rej;
      end
   end

   // Storage array; contents survive reset and are simply abandoned.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // First-word fall-through head.
   assign rd_data = mem[rd_ptr];

endmodule
